// File: rtl/ipa_ctx_loader.sv
// IPA context loader: fetches a header plus address/data pairs from the two GCM
// banks, writes each pair into CGRA configuration memory, then runs the CGRA.
module ipa_ctx_loader #(
  parameter int GCM_ADDR_WIDTH = 12,
  parameter int CFG_ADDR_WIDTH = 23,
  parameter int MAX_ENTRIES    = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [GCM_ADDR_WIDTH-1:0] base_addr_i,
  output logic                      gcm_req_o,
  output logic [GCM_ADDR_WIDTH-1:0] gcm_addr_o,
  input  logic [31:0]               gcm_rdata_hi_i,
  input  logic [31:0]               gcm_rdata_lo_i,
  input  logic                      gcm_rvalid_i,
  output logic                      cfg_we_o,
  output logic [CFG_ADDR_WIDTH-1:0] cfg_addr_o,
  output logic [63:0]               cfg_data_o,
  output logic                      exec_en_o,
  input  logic                      exec_done_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  // Counters hold up to 2*MAX_ENTRIES (one request/response per word).
  localparam int CNT_W = $clog2(2 * MAX_ENTRIES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_REQ,
    S_HDR_WAIT,
    S_FETCH,
    S_EXEC
  } state_e;

  state_e                    state_q, state_d;
  logic [GCM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_W-1:0]          n2_q, n2_d;
  logic [CNT_W-1:0]          req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]          rsp_cnt_q, rsp_cnt_d;
  logic [CFG_ADDR_WIDTH-1:0] addr_lat_q, addr_lat_d;
  logic                      cfg_we_q, cfg_we_d;
  logic [CFG_ADDR_WIDTH-1:0] cfg_addr_q, cfg_addr_d;
  logic [63:0]               cfg_data_q, cfg_data_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic [63:0] rword;
  logic [15:0] hdr_n;
  logic        hdr_too_big;
  logic        req_left;

  assign rword       = {gcm_rdata_hi_i, gcm_rdata_lo_i};
  assign hdr_n       = gcm_rdata_lo_i[15:0];
  assign hdr_too_big = ({16'd0, hdr_n} > 32'(MAX_ENTRIES));
  assign req_left    = (req_cnt_q != n2_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      n2_q       <= '0;
      req_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      addr_lat_q <= '0;
      cfg_we_q   <= 1'b0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      n2_q       <= n2_d;
      req_cnt_q  <= req_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      addr_lat_q <= addr_lat_d;
      cfg_we_q   <= cfg_we_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    n2_d       = n2_q;
    req_cnt_d  = req_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;
    addr_lat_d = addr_lat_q;
    cfg_we_d   = 1'b0;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    done_d     = 1'b0;
    err_d      = err_q;

    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            base_d    = base_addr_i;
            err_d     = 1'b0;
            req_cnt_d = '0;
            rsp_cnt_d = '0;
            state_d   = S_HDR_REQ;
          end
        end
        S_HDR_REQ: state_d = S_HDR_WAIT;
        S_HDR_WAIT: begin
          if (gcm_rvalid_i) begin
            if (hdr_n == 16'd0) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else if (hdr_too_big) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              n2_d    = CNT_W'({hdr_n, 1'b0});
              state_d = S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (req_left) req_cnt_d = req_cnt_q + CNT_W'(1);
          // Even responses carry the address, odd ones the data to write.
          if (gcm_rvalid_i && (rsp_cnt_q != n2_q)) begin
            if (!rsp_cnt_q[0]) begin
              addr_lat_d = rword[CFG_ADDR_WIDTH-1:0];
            end else begin
              cfg_we_d   = 1'b1;
              cfg_addr_d = addr_lat_q;
              cfg_data_d = rword;
            end
            rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
          end
          // Leave only once the strobe for the final pair is on the port.
          if (cfg_we_q && (rsp_cnt_q == n2_q)) state_d = S_EXEC;
        end
        S_EXEC: begin
          if (exec_done_i) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign gcm_req_o  = (state_q == S_HDR_REQ) || ((state_q == S_FETCH) && req_left);
  assign gcm_addr_o = (state_q == S_FETCH)
                      ? base_q + GCM_ADDR_WIDTH'(req_cnt_q) + GCM_ADDR_WIDTH'(1)
                      : base_q;
  assign cfg_we_o   = cfg_we_q;
  assign cfg_addr_o = cfg_addr_q;
  assign cfg_data_o = cfg_data_q;
  assign exec_en_o  = (state_q == S_EXEC);
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_ipa_ctx_loader.sv
// Bench for ipa_ctx_loader: GCM memory model, event monitor and directed plus
// randomized context loads compared against expectations built from the image.
module tb_ipa_ctx_loader;
  localparam int GAW  = 12;
  localparam int CAW  = 23;
  localparam int MAXE = 1024;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_i = 1'b0;
  logic           abort_i = 1'b0;
  logic [GAW-1:0] base_addr_i = '0;
  logic           gcm_req_o;
  logic [GAW-1:0] gcm_addr_o;
  logic [31:0]    rhi = '0;
  logic [31:0]    rlo = '0;
  logic           rvalid = 1'b0;
  logic           cfg_we_o;
  logic [CAW-1:0] cfg_addr_o;
  logic [63:0]    cfg_data_o;
  logic           exec_en_o;
  logic           exec_done_i = 1'b0;
  logic           busy_o;
  logic           done_o;
  logic           err_o;

  ipa_ctx_loader #(
    .GCM_ADDR_WIDTH(GAW),
    .CFG_ADDR_WIDTH(CAW),
    .MAX_ENTRIES   (MAXE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .base_addr_i   (base_addr_i),
    .gcm_req_o     (gcm_req_o),
    .gcm_addr_o    (gcm_addr_o),
    .gcm_rdata_hi_i(rhi),
    .gcm_rdata_lo_i(rlo),
    .gcm_rvalid_i  (rvalid),
    .cfg_we_o      (cfg_we_o),
    .cfg_addr_o    (cfg_addr_o),
    .cfg_data_o    (cfg_data_o),
    .exec_en_o     (exec_en_o),
    .exec_done_i   (exec_done_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // GCM banks: always grant, data one cycle after the request.
  logic [31:0] mem_hi [4096];
  logic [31:0] mem_lo [4096];
  always @(posedge clk) begin
    rvalid <= gcm_req_o;
    if (gcm_req_o) begin
      rhi <= mem_hi[gcm_addr_o];
      rlo <= mem_lo[gcm_addr_o];
    end
  end

  typedef struct {
    int          c;
    logic [63:0] a;
    logic [63:0] d;
  } ev_t;
  ev_t we_q[$];
  ev_t req_q[$];
  int  done_q[$];
  int  exec_q[$];

  always @(negedge clk) begin
    if (cfg_we_o)  we_q.push_back('{c: cyc, a: 64'(cfg_addr_o), d: cfg_data_o});
    if (gcm_req_o) req_q.push_back('{c: cyc, a: 64'(gcm_addr_o), d: 64'd0});
    if (done_o)    done_q.push_back(cyc);
    if (exec_en_o) exec_q.push_back(cyc);
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [63:0] ent_aw [64];
  logic [63:0] ent_dw [64];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    we_q.delete();
    req_q.delete();
    done_q.delete();
    exec_q.delete();
  endtask

  task automatic rand_entries(input int n);
    for (int k = 0; k < n && k < 64; k++) begin
      ent_aw[k] = {$urandom, $urandom};
      ent_dw[k] = {$urandom, $urandom};
    end
  endtask

  task automatic put_image(input logic [GAW-1:0] base, input int n);
    logic [GAW-1:0] r;
    mem_hi[base] = $urandom;
    mem_lo[base] = {16'($urandom), 16'(n)};
    for (int k = 0; k < n && k < 64; k++) begin
      r = base + GAW'(2 * k + 1);
      mem_hi[r] = ent_aw[k][63:32];
      mem_lo[r] = ent_aw[k][31:0];
      r = r + GAW'(1);
      mem_hi[r] = ent_dw[k][63:32];
      mem_lo[r] = ent_dw[k][31:0];
    end
  endtask

  task automatic start_pulse(input logic [GAW-1:0] base, output int t);
    tick();
    clear_mon();
    base_addr_i = base;
    start_i     = 1'b1;
    t           = cyc;
    tick();
    start_i     = 1'b0;
    base_addr_i = '0;
  endtask

  // One complete start..done sequence with expectations from the image contents.
  task automatic do_txn(input logic [GAW-1:0] base, input int n, input int lat, input bit dup);
    int             t;
    int             e;
    logic [GAW-1:0] r;
    put_image(base, n);
    start_pulse(base, t);
    chk("busy_at_T1", 64'(busy_o), 64'd1);
    chk("hdr_req", 64'(gcm_req_o), 64'd1);
    chk("hdr_addr", 64'(gcm_addr_o), 64'(base));
    chk("err_cleared", 64'(err_o), 64'd0);
    if (dup) begin
      while (cyc < t + 3) tick();
      start_i     = 1'b1;
      base_addr_i = base ^ GAW'(12'h5A5);
      tick();
      start_i     = 1'b0;
      base_addr_i = '0;
    end
    if (n == 0 || n > MAXE) begin
      while (cyc < t + 3) tick();
      chk("hdr_done", 64'(done_o), 64'(n == 0));
      chk("hdr_err", 64'(err_o), 64'(n > MAXE));
      chk("hdr_busy", 64'(busy_o), 64'd0);
      tick();
      chk("hdr_done_pulse", 64'(done_o), 64'd0);
      tick();
      chk("hdr_no_we", 64'(we_q.size()), 64'd0);
      chk("hdr_no_exec", 64'(exec_q.size()), 64'd0);
      chk("hdr_req_count", 64'(req_q.size()), 64'd1);
      chk("hdr_done_count", 64'(done_q.size()), 64'(n == 0));
    end else begin
      e = t + 5 + 2 * n + lat;
      while (cyc < t + 5 + 2 * n) tick();
      chk("exec_en_start", 64'(exec_en_o), 64'd1);
      while (cyc < e) tick();
      exec_done_i = 1'b1;
      tick();
      exec_done_i = 1'b0;
      chk("done_pulse", 64'(done_o), 64'd1);
      chk("exec_en_off", 64'(exec_en_o), 64'd0);
      chk("busy_off", 64'(busy_o), 64'd0);
      tick();
      chk("done_single", 64'(done_o), 64'd0);
      chk("req_count", 64'(req_q.size()), 64'(2 * n + 1));
      for (int i = 0; i < req_q.size() && i <= 2 * n; i++) begin
        r = base + GAW'(i);
        chk("req_cycle", 64'(req_q[i].c), 64'((i == 0) ? t + 1 : t + 2 + i));
        chk("req_row", req_q[i].a, 64'(r));
      end
      chk("we_count", 64'(we_q.size()), 64'(n));
      for (int k = 0; k < we_q.size() && k < n; k++) begin
        chk("we_cycle", 64'(we_q[k].c), 64'(t + 6 + 2 * k));
        chk("we_addr", we_q[k].a, ent_aw[k] & 64'h7F_FFFF);
        chk("we_data", we_q[k].d, ent_dw[k]);
      end
      chk("exec_len", 64'(exec_q.size()), 64'(lat + 1));
      if (exec_q.size() > 0) chk("exec_first", 64'(exec_q[0]), 64'(t + 5 + 2 * n));
      chk("done_count", 64'(done_q.size()), 64'd1);
      if (done_q.size() > 0) chk("done_cycle", 64'(done_q[0]), 64'(e + 1));
    end
  endtask

  initial begin
    int             t;
    logic [GAW-1:0] b;
    for (int i = 0; i < 4096; i++) begin
      mem_hi[i] = '0;
      mem_lo[i] = '0;
    end

    #2;
    chk("rst_req", 64'(gcm_req_o), 64'd0);
    chk("rst_we", 64'(cfg_we_o), 64'd0);
    chk("rst_cfg_addr", 64'(cfg_addr_o), 64'd0);
    chk("rst_cfg_data", cfg_data_o, 64'd0);
    chk("rst_exec", 64'(exec_en_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic load from the test plan; exec_done at T+20.
    ent_aw[0] = 64'h5;
    ent_dw[0] = 64'h1111_2222_3333_4444;
    ent_aw[1] = 64'h7F_FFFF;
    ent_dw[1] = 64'hDEAD_BEEF_0000_0001;
    do_txn(12'h010, 2, 11, 1'b0);

    // Wrap-around plus bank ordering.
    ent_aw[0] = {$urandom, $urandom};
    ent_dw[0] = 64'hAAAA_AAAA_5555_5555;
    do_txn(12'hFFE, 1, 2, 1'b0);

    // Oversized header, then exec_done in IDLE, then empty header.
    do_txn(GAW'($urandom), 1025, 0, 1'b0);
    exec_done_i = 1'b1;
    tick();
    exec_done_i = 1'b0;
    chk("idle_exec_done", 64'(done_o), 64'd0);
    chk("idle_busy", 64'(busy_o), 64'd0);
    chk("err_sticky", 64'(err_o), 64'd1);
    do_txn(GAW'($urandom), 0, 0, 1'b0);

    // Randomized loads, one with a start pulse while busy.
    for (int it = 0; it < 5; it++) begin
      int n;
      n = int'($urandom_range(1, 6));
      rand_entries(n);
      do_txn(GAW'($urandom), n, int'($urandom_range(0, 5)), it == 2);
    end

    // Abort after the first write.
    rand_entries(4);
    b = GAW'($urandom);
    put_image(b, 4);
    start_pulse(b, t);
    while (cyc < t + 6) tick();
    chk("abort_first_we", 64'(cfg_we_o), 64'd1);
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_req", 64'(gcm_req_o), 64'd0);
    chk("abort_we", 64'(cfg_we_o), 64'd0);
    chk("abort_exec", 64'(exec_en_o), 64'd0);
    repeat (15) tick();
    chk("abort_we_count", 64'(we_q.size()), 64'd1);
    chk("abort_no_exec", 64'(exec_q.size()), 64'd0);
    chk("abort_no_done", 64'(done_q.size()), 64'd0);
    rand_entries(3);
    do_txn(GAW'($urandom), 3, 1, 1'b0);

    // Asynchronous reset mid-fetch.
    rand_entries(4);
    b = GAW'($urandom);
    put_image(b, 4);
    start_pulse(b, t);
    while (cyc < t + 7) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(gcm_req_o), 64'd0);
    chk("mid_rst_addr", 64'(gcm_addr_o), 64'd0);
    chk("mid_rst_cfg_addr", 64'(cfg_addr_o), 64'd0);
    chk("mid_rst_cfg_data", cfg_data_o, 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_exec", 64'(exec_en_o), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    clear_mon();
    repeat (10) tick();
    chk("post_rst_we", 64'(we_q.size()), 64'd0);
    chk("post_rst_req", 64'(req_q.size()), 64'd0);
    chk("post_rst_done", 64'(done_q.size()), 64'd0);
    chk("post_rst_exec", 64'(exec_q.size()), 64'd0);
    rand_entries(2);
    do_txn(GAW'($urandom), 2, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
